lsu_split_access: RTL
=====================

Name: lsu_split_access

Overview:
- Parametrised load/store access sequencer between the LSU issue stage and the data-cache port.
- Accepts one byte/half/word/(double) access and generates byte-enable masks and lane-aligned write data.
- Splits any access that crosses an XLEN/8-byte boundary into two bus transactions, then merges and sign/zero-extends load data.
- Supersedes the purely combinational mask/align path for XLEN in {32,64} and adds misaligned support plus fault reporting.

Parameters:
- XLEN, 32, data bus and register width; legal values 32 or 64; B = XLEN/8 bytes per beat.
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses; 0 = report them as faults.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0=b, 1=h, 2=w, 3=d (d legal only when XLEN=64)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  XLEN  store data, right-justified
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
- rsp_fault  out  1  illegal size, or misaligned with ALLOW_MISALIGNED=0
- mem_read  out  1  read request, held until mem_resp
- mem_write  out  1  write request, held until mem_resp
- mem_addr  out  32  beat-aligned address (low log2(B) bits = 0)
- mem_mbe  out  B  byte enables
- mem_wdata  out  XLEN  lane-aligned write data
- mem_resp  in  1  one-cycle completion of the current beat
- mem_rdata  in  XLEN  read data, valid with mem_resp

Behaviour:
- Reset values: FSM=IDLE; req_ready=1; rsp_valid=0; rsp_fault=0; rsp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_mbe=0; mem_wdata=0.
- States and transitions:
  - IDLE: on req_valid && req_ready, latch all req fields.
    - Fault -> RESP.
    - Otherwise -> BEAT0.
  - BEAT0: drive beat 0 until mem_resp.
    - Split access -> BEAT1.
    - Else -> RESP.
  - BEAT1: drive beat 1 until mem_resp -> RESP.
  - RESP: rsp_valid=1 until rsp_ready -> IDLE. No new request is accepted in the same cycle.
- Definitions: off = addr mod B; n = 1<<size; split = (off+n > B).
- Fault:
  - size=3 when XLEN=32, or split with ALLOW_MISALIGNED=0.
  - No mem_read/mem_write is asserted.
  - rsp_fault=1 for exactly that response.
- Beat 0 outputs:
  - mem_addr = addr & ~(B-1).
  - mem_mbe = ((1<<n)-1) << off, truncated to B bits.
  - mem_wdata = wdata << 8*off.
- Beat 1 outputs:
  - mem_addr = beat-0 address + B, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
  - mem_mbe = ((1<<n)-1) >> (B-off).
  - mem_wdata = wdata >> 8*(B-off).
- mem_read = !store and mem_write = store. Both are high only in BEAT0/BEAT1 and never high together. Outputs are stable while waiting for mem_resp.
- Load merge:
  - Beat-0 bytes: mem_rdata >> 8*off, stored in a holding register.
  - Beat-1 bytes: mem_rdata << 8*(B-off), ORed in.
  - Keep the low n bytes, then sign- or zero-extend to XLEN.
- Latency:
  - Request accepted at cycle T; mem_read/mem_write asserted at T+1.
  - Unsplit: final mem_resp at cycle M, rsp_valid at M+1.
  - Split: beat 1 asserted the cycle after beat-0 mem_resp.
  - Fault: rsp_valid at T+1.
- mem_resp outside BEAT0/BEAT1 is ignored.
- rst in any state forces IDLE the next cycle. mem_read/mem_write drop that cycle, and any in-flight beat is abandoned.
- mem_mbe=0 and mem_wdata=0 whenever neither request is asserted.

Test Plan:
1. XLEN=32, lb addr 0x103, mem_rdata 0x80112233 -> one beat: mem_addr 0x100, mbe 0001/1000 pattern 4'b1000; rsp_rdata 0xFFFFFF80, fault 0.
2. XLEN=32, sw addr 0x202, wdata 0xAABBCCDD -> beat0: addr 0x200, mbe 4'b1100, wdata 0xCCDD0000; beat1: addr 0x204, mbe 4'b0011, wdata 0x0000AABB.
3. XLEN=32, lhu addr 0x0FFFFFFFF, beat0 rdata 0x7F000000, beat1 rdata 0x000000FE -> beat1 addr 0x0 (wrap); rsp_rdata 0x0000FE7F.
4. XLEN=64, ld addr 0x1004, rdata 0x11223344_55667788 then 0x99AABBCC_DDEEFF00 -> mbe 8'hF0 then 8'h0F; rsp_rdata 0xDDEEFF00_11223344.
5. ALLOW_MISALIGNED=0, lw addr 0x6 -> no mem_read; rsp_valid at T+1 with rsp_fault=1, rsp_rdata=0. Separately, XLEN=32 with size=3 -> same fault response.
6. Assert rst during BEAT1 of a split store -> mem_write=0 the next cycle, req_ready=1, rsp_valid stays 0. A stale mem_resp then arrives -> ignored. Also: rsp_ready held low for 3 cycles -> rsp_valid and data stable, req_ready=0 throughout.

Source files
------------

// File: rtl/lsu_split_access_if.sv
// Request, response and data-cache port bundle for lsu_split_access.
// The slave modport is the sequencer; the master modport is its environment (issue stage plus cache).
interface lsu_split_access_if #(
    parameter int XLEN = 32
);
    localparam int B = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_store;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [31:0]     req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_fault;

    logic            mem_read;
    logic            mem_write;
    logic [31:0]     mem_addr;
    logic [B-1:0]    mem_mbe;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_resp;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_fault,
        input  rsp_ready,
        output mem_read, mem_write, mem_addr, mem_mbe, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_fault,
        output rsp_ready,
        input  mem_read, mem_write, mem_addr, mem_mbe, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/lsu_split_access.sv
// Load/store access sequencer: byte-enable and lane alignment, split of boundary-crossing
// accesses into two cache beats, load merge with sign/zero extension, and fault reporting.
module lsu_split_access #(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    lsu_split_access_if.slave bus
);
    localparam int B    = XLEN / 8;
    localparam int OFFW = $clog2(B);
    localparam int IDXW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            store_q, store_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            split_q, split_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] hold_q, hold_d;

    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_fault_q, rsp_fault_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [B-1:0]    mem_mbe_q, mem_mbe_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

    logic [OFFW-1:0]   sel_off;
    logic [1:0]        sel_size;
    logic [XLEN-1:0]   sel_wdata;
    logic [2*B-1:0]    mbe_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic [OFFW:0]     rem;
    logic [XLEN-1:0]   beat0_rd;
    logic [XLEN-1:0]   merged_rd;
    logic              req_split;
    logic              req_fault;

    function automatic logic access_split(input logic [OFFW-1:0] off, input logic [1:0] sz);
        logic [4:0] span;
        span = 5'(off) + (5'd1 << sz);
        return span > 5'(B);
    endfunction

    // A full-width access shifts every bit out, so its complement is all ones.
    function automatic logic [B-1:0] lane_mask(input logic [1:0] sz);
        return ~({B{1'b1}} << (4'd1 << sz));
    endfunction

    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                                    input logic uns);
        int              nbits;
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] keep;
        logic [XLEN-1:0] r;
        nbits = 32'd8 << sz;
        keep  = ~({XLEN{1'b1}} << nbits);
        if (nbits >= XLEN) begin
            idx = IDXW'(XLEN - 1);
        end else begin
            idx = IDXW'(nbits - 1);
        end
        r = d & keep;
        if (!uns && d[idx]) begin
            r = r | ~keep;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Lane alignment and load-merge datapath shared by both beats.
    always_comb begin
        if (state_q == IDLE) begin
            sel_off   = bus.req_addr[OFFW-1:0];
            sel_size  = bus.req_size;
            sel_wdata = bus.req_wdata;
        end else begin
            sel_off   = off_q;
            sel_size  = size_q;
            sel_wdata = wdata_q;
        end
        mbe_wide   = {{B{1'b0}}, lane_mask(sel_size)} << sel_off;
        wdata_wide = {{XLEN{1'b0}}, sel_wdata} << {sel_off, 3'b000};
        rem        = (OFFW+1)'(B) - {1'b0, off_q};
        beat0_rd   = bus.mem_rdata >> {off_q, 3'b000};
        merged_rd  = hold_q | (bus.mem_rdata << {rem, 3'b000});
        req_split  = access_split(bus.req_addr[OFFW-1:0], bus.req_size);
        req_fault  = ((bus.req_size == 2'd3) && (XLEN != 64)) || (req_split && !ALLOW_MISALIGNED);
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        split_d     = split_q;
        wdata_d     = wdata_q;
        hold_d      = hold_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_mbe_d   = mem_mbe_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    store_d     = bus.req_store;
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    off_d       = bus.req_addr[OFFW-1:0];
                    split_d     = req_split;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (req_fault) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_rdata_d = {XLEN{1'b0}};
                    end else begin
                        state_d     = BEAT0;
                        mem_read_d  = !bus.req_store;
                        mem_write_d = bus.req_store;
                        mem_addr_d  = {bus.req_addr[31:OFFW], {OFFW{1'b0}}};
                        mem_mbe_d   = mbe_wide[B-1:0];
                        mem_wdata_d = wdata_wide[XLEN-1:0];
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            BEAT0: begin
                if (bus.mem_resp) begin
                    hold_d = beat0_rd;
                    if (split_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + 32'(B);
                        mem_mbe_d   = mbe_wide[2*B-1:B];
                        mem_wdata_d = wdata_wide[2*XLEN-1:XLEN];
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b0;
                        rsp_rdata_d = store_q ? {XLEN{1'b0}} : extend_load(beat0_rd, size_q, uns_q);
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        mem_addr_d  = 32'd0;
                        mem_mbe_d   = {B{1'b0}};
                        mem_wdata_d = {XLEN{1'b0}};
                    end
                end else begin
                    state_d = BEAT0;
                end
            end
            BEAT1: begin
                if (bus.mem_resp) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = store_q ? {XLEN{1'b0}} : extend_load(merged_rd, size_q, uns_q);
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_mbe_d   = {B{1'b0}};
                    mem_wdata_d = {XLEN{1'b0}};
                end else begin
                    state_d = BEAT1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = {XLEN{1'b0}};
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_fault_d = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= {OFFW{1'b0}};
            split_q     <= 1'b0;
            wdata_q     <= {XLEN{1'b0}};
            hold_q      <= {XLEN{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= {XLEN{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_mbe_q   <= {B{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            split_q     <= split_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_mbe_q   <= mem_mbe_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_mbe   = mem_mbe_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
